// File: rtl/alu_decode_stage_if.sv
// Handshake and operand bus between fetch, the register file, the decode stage and the ALU.
interface alu_decode_stage_if #(
  parameter int unsigned ENABLE_W   = 41,
  parameter int unsigned REG_ADDR_W = 3
);

  localparam int unsigned WORD_W = 16;

  // fetch side
  logic [WORD_W-1:0]     instr_in;
  logic                  instr_valid;
  logic                  instr_ready;
  logic                  flush;
  logic                  psw_c;

  // register file read ports
  logic [REG_ADDR_W-1:0] rf_src_addr;
  logic [REG_ADDR_W-1:0] rf_dst_addr;
  logic [WORD_W-1:0]     rf_src_data;
  logic [WORD_W-1:0]     rf_dst_data;

  // execute side
  logic [WORD_W-1:0]     alu_a;
  logic [WORD_W-1:0]     alu_b;
  logic [ENABLE_W-1:0]   alu_enable;
  logic                  alu_carry_in;
  logic [REG_ADDR_W-1:0] wb_addr;
  logic                  wb_en;
  logic                  wb_byte;
  logic                  out_valid;
  logic                  out_ready;
  logic                  illegal;

  // environment view: drives fetch, register data and execute-ready
  modport master (
    output instr_in, instr_valid, flush, psw_c,
    output rf_src_data, rf_dst_data, out_ready,
    input  instr_ready, rf_src_addr, rf_dst_addr,
    input  alu_a, alu_b, alu_enable, alu_carry_in,
    input  wb_addr, wb_en, wb_byte, out_valid, illegal
  );

  // decode stage view
  modport slave (
    input  instr_in, instr_valid, flush, psw_c,
    input  rf_src_data, rf_dst_data, out_ready,
    output instr_ready, rf_src_addr, rf_dst_addr,
    output alu_a, alu_b, alu_enable, alu_carry_in,
    output wb_addr, wb_en, wb_byte, out_valid, illegal
  );

endinterface

// File: rtl/alu_decode_stage.sv
// XM23 arithmetic/logic group decode and operand-issue stage (opcodes 0x4000-0x4BFF).
module alu_decode_stage #(
  parameter int unsigned ENABLE_W   = 41,
  parameter int unsigned REG_ADDR_W = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  alu_decode_stage_if.slave bus
);

  localparam int unsigned WORD_W  = 16;
  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned IDX_W   = 6;
  localparam int unsigned OP_W    = 4;

  // first alu_enable bit of the group; bit = OP_BASE + instr[11:8]
  localparam int unsigned OP_BASE = 9;

  // group opcodes (instr[11:8]) that never write back
  localparam logic [OP_W-1:0] OP_CMP = 4'h5;
  localparam logic [OP_W-1:0] OP_BIT = 4'h9;

  // legal range of instr[15:8]
  localparam logic [BYTE_W-1:0] HI_MIN = 8'h40;
  localparam logic [BYTE_W-1:0] HI_MAX = 8'h4B;

  // constant generator selected by the source field when R/C = 1
  function automatic logic [WORD_W-1:0] const_val(input logic [2:0] sel);
    logic [WORD_W-1:0] v;
    v = '0;
    case (sel)
      3'd0:    v = 16'h0000;
      3'd1:    v = 16'h0001;
      3'd2:    v = 16'h0002;
      3'd3:    v = 16'h0004;
      3'd4:    v = 16'h0008;
      3'd5:    v = 16'h0010;
      3'd6:    v = 16'h0020;
      default: v = 16'hFFFF;
    endcase
    return v;
  endfunction

  // handshake
  logic take_in_c;
  logic take_out_c;
  logic instr_ready_c;

  // decoded next values
  logic [BYTE_W-1:0]     hi_c;
  logic [OP_W-1:0]       op_c;
  logic                  legal_c;
  logic                  rc_c;
  logic                  byte_c;
  logic [IDX_W-1:0]      bit_idx_c;
  logic [ENABLE_W-1:0]   enable_nxt;
  logic [WORD_W-1:0]     a_full_c;
  logic [WORD_W-1:0]     a_nxt;
  logic [WORD_W-1:0]     b_nxt;
  logic                  wb_en_nxt;

  // output registers
  logic                  out_valid_q;
  logic                  illegal_q;
  logic [ENABLE_W-1:0]   enable_q;
  logic [WORD_W-1:0]     alu_a_q;
  logic [WORD_W-1:0]     alu_b_q;
  logic                  carry_q;
  logic [REG_ADDR_W-1:0] wb_addr_q;
  logic                  wb_en_q;
  logic                  wb_byte_q;

  // ready whenever the output slot is empty or being drained this cycle
  assign instr_ready_c = !out_valid_q || bus.out_ready;
  assign take_in_c     = bus.instr_valid && instr_ready_c;
  assign take_out_c    = out_valid_q && bus.out_ready;

  // register file is addressed straight from the incoming word
  assign bus.rf_src_addr = REG_ADDR_W'(bus.instr_in[5:3]);
  assign bus.rf_dst_addr = REG_ADDR_W'(bus.instr_in[2:0]);

  // decode the incoming word into mode vector, operands and writeback control
  always_comb begin
    hi_c       = bus.instr_in[15:8];
    op_c       = bus.instr_in[11:8];
    rc_c       = bus.instr_in[7];
    byte_c     = bus.instr_in[6];
    legal_c    = (hi_c >= HI_MIN) && (hi_c <= HI_MAX);
    bit_idx_c  = IDX_W'(OP_BASE) + IDX_W'(op_c);
    enable_nxt = '0;
    if (legal_c) begin
      enable_nxt[bit_idx_c] = 1'b1;
    end

    a_full_c = rc_c ? const_val(bus.instr_in[5:3]) : bus.rf_src_data;
    a_nxt    = a_full_c;
    b_nxt    = bus.rf_dst_data;
    if (byte_c) begin
      a_nxt = {BYTE_W'(0), a_full_c[BYTE_W-1:0]};
      b_nxt = {BYTE_W'(0), bus.rf_dst_data[BYTE_W-1:0]};
    end

    wb_en_nxt = legal_c && (op_c != OP_CMP) && (op_c != OP_BIT);
  end

  // output slot: flush beats load, load beats drain, otherwise hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      illegal_q   <= 1'b0;
      enable_q    <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      carry_q     <= 1'b0;
      wb_addr_q   <= '0;
      wb_en_q     <= 1'b0;
      wb_byte_q   <= 1'b0;
    end else if (bus.flush) begin
      out_valid_q <= 1'b0;
      illegal_q   <= 1'b0;
      enable_q    <= '0;
      wb_en_q     <= 1'b0;
    end else if (take_in_c) begin
      out_valid_q <= 1'b1;
      illegal_q   <= !legal_c;
      enable_q    <= enable_nxt;
      alu_a_q     <= a_nxt;
      alu_b_q     <= b_nxt;
      carry_q     <= bus.psw_c;
      wb_addr_q   <= REG_ADDR_W'(bus.instr_in[2:0]);
      wb_en_q     <= wb_en_nxt;
      wb_byte_q   <= byte_c;
    end else if (take_out_c) begin
      out_valid_q <= 1'b0;
    end
  end

  // drive the execute-side bus from the output registers
  assign bus.instr_ready  = instr_ready_c;
  assign bus.out_valid    = out_valid_q;
  assign bus.illegal      = illegal_q;
  assign bus.alu_enable   = enable_q;
  assign bus.alu_a        = alu_a_q;
  assign bus.alu_b        = alu_b_q;
  assign bus.alu_carry_in = carry_q;
  assign bus.wb_addr      = wb_addr_q;
  assign bus.wb_en        = wb_en_q;
  assign bus.wb_byte      = wb_byte_q;

endmodule

// File: tb/tb_alu_decode_stage.sv
// Scoreboard bench for alu_decode_stage.
module tb_alu_decode_stage;

  typedef struct packed {
    logic [40:0] en;
    logic [15:0] a;
    logic [15:0] b;
    logic        c;
    logic [2:0]  wa;
    logic        we;
    logic        wbyte;
    logic        ill;
  } exp_t;

  logic clk;
  logic rst_n;
  logic [15:0] rf [8];
  exp_t q[$];
  int n_checks;
  int n_fail;
  int n_pushed;
  int n_popped;

  alu_decode_stage_if #(.ENABLE_W(41), .REG_ADDR_W(3)) bus ();

  alu_decode_stage #(.ENABLE_W(41), .REG_ADDR_W(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // combinational register file model
  always_comb begin
    bus.rf_src_data = rf[bus.rf_src_addr];
    bus.rf_dst_data = rf[bus.rf_dst_addr];
  end

  // reference decode written from the opcode table
  function automatic exp_t model(input logic [15:0] ins, input logic [15:0] rs,
                                 input logic [15:0] rd, input logic c);
    exp_t e;
    int bitn;
    logic [15:0] k;
    e = '0;
    case (ins[15:8])
      8'h40: bitn = 9;   8'h41: bitn = 10;  8'h42: bitn = 11;  8'h43: bitn = 12;
      8'h44: bitn = 13;  8'h45: bitn = 14;  8'h46: bitn = 15;  8'h47: bitn = 16;
      8'h48: bitn = 17;  8'h49: bitn = 18;  8'h4A: bitn = 19;  8'h4B: bitn = 20;
      default: bitn = -1;
    endcase
    case (ins[5:3])
      3'd0: k = 16'd0;   3'd1: k = 16'd1;   3'd2: k = 16'd2;   3'd3: k = 16'd4;
      3'd4: k = 16'd8;   3'd5: k = 16'd16;  3'd6: k = 16'd32;  default: k = 16'hFFFF;
    endcase
    if (bitn >= 0) e.en[bitn] = 1'b1;
    e.a = ins[7] ? k : rs;
    e.b = rd;
    if (ins[6]) begin
      e.a = e.a & 16'h00FF;
      e.b = e.b & 16'h00FF;
    end
    e.c     = c;
    e.wa    = ins[2:0];
    e.wbyte = ins[6];
    e.ill   = (bitn < 0);
    e.we    = (bitn >= 0) && (bitn != 14) && (bitn != 18);
    return e;
  endfunction

  // one clock: drive, check handshake and held op, advance the model
  task automatic step(input logic v, input logic [15:0] ins, input logic rdy,
                      input logic fl, output logic took);
    logic exp_rdy;
    exp_t e;
    exp_t o;
    bus.instr_valid = v;
    bus.instr_in    = ins;
    bus.out_ready   = rdy;
    bus.flush       = fl;
    #1;
    exp_rdy = (q.size() == 0) || rdy;
    n_checks++;
    if (bus.instr_ready !== exp_rdy) begin
      n_fail++;
      $display("FAIL instr_ready: got %b expected %b", bus.instr_ready, exp_rdy);
    end
    n_checks++;
    if (bus.out_valid !== (q.size() != 0)) begin
      n_fail++;
      $display("FAIL out_valid: got %b expected %b", bus.out_valid, q.size() != 0);
    end
    if (!fl && q.size() > 0) begin
      o.en = bus.alu_enable; o.a = bus.alu_a; o.b = bus.alu_b; o.c = bus.alu_carry_in;
      o.wa = bus.wb_addr; o.we = bus.wb_en; o.wbyte = bus.wb_byte; o.ill = bus.illegal;
      n_checks++;
      if (o !== q[0]) begin
        n_fail++;
        $display("FAIL op_payload: got %h expected %h", o, q[0]);
      end
      if (rdy) begin
        void'(q.pop_front());
        n_popped++;
      end
    end
    e = model(ins, rf[ins[5:3]], rf[ins[2:0]], bus.psw_c);
    took = v && exp_rdy && !fl;
    @(posedge clk);
    #1;
    if (fl) q.delete();
    else if (took) begin
      q.push_back(e);
      n_pushed++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.instr_valid = 1'b0; bus.instr_in = '0; bus.flush = 1'b0;
    bus.out_ready = 1'b0; bus.psw_c = 1'b0;
    for (int i = 0; i < 8; i++) rf[i] = 16'(i * 16'h1111);
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({bus.out_valid, bus.illegal, bus.wb_en, bus.wb_byte, bus.alu_carry_in} !== 5'b0 ||
        bus.alu_enable !== 41'd0 || bus.alu_a !== 16'd0 || bus.alu_b !== 16'd0 ||
        bus.wb_addr !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got valid=%b ill=%b en=%h a=%h b=%h expected all zero",
               bus.out_valid, bus.illegal, bus.alu_enable, bus.alu_a, bus.alu_b);
    end
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (bus.instr_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready: got %b expected 1", bus.instr_ready);
    end
  endtask

  task automatic test_add();
    logic t;
    logic [40:0] exp_en;
    rf[0] = 16'd5;
    bus.psw_c = 1'b0;
    exp_en = 41'd1 << 9;
    step(1'b1, 16'h4000, 1'b1, 1'b0, t);
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.alu_enable !== exp_en || bus.alu_a !== 16'd5 ||
        bus.alu_b !== 16'd5 || bus.wb_en !== 1'b1 || bus.wb_addr !== 3'd0) begin
      n_fail++;
      $display("FAIL add_direct: got v=%b en=%h a=%h b=%h we=%b wa=%0d expected v=1 en=%h a=5 b=5 we=1 wa=0",
               bus.out_valid, bus.alu_enable, bus.alu_a, bus.alu_b, bus.wb_en, bus.wb_addr, exp_en);
    end
    step(1'b0, 16'h0000, 1'b1, 1'b0, t);
  endtask

  task automatic test_subc_const();
    logic t;
    logic [40:0] exp_en;
    rf[1] = 16'h1234;
    bus.psw_c = 1'b1;
    exp_en = 41'd1 << 12;
    step(1'b1, 16'h43B9, 1'b1, 1'b0, t);
    n_checks++;
    if (bus.alu_enable !== exp_en || bus.alu_a !== 16'hFFFF || bus.alu_b !== 16'h1234 ||
        bus.alu_carry_in !== 1'b1) begin
      n_fail++;
      $display("FAIL subc_direct: got en=%h a=%h b=%h c=%b expected en=%h a=ffff b=1234 c=1",
               bus.alu_enable, bus.alu_a, bus.alu_b, bus.alu_carry_in, exp_en);
    end
    bus.psw_c = 1'b0;
    step(1'b0, 16'h0000, 1'b1, 1'b0, t);
  endtask

  task automatic test_cmp_byte();
    logic t;
    rf[2] = 16'hABCD;
    step(1'b1, 16'h4552, 1'b1, 1'b0, t);
    n_checks++;
    if (bus.alu_a !== 16'h00CD || bus.alu_b !== 16'h00CD || bus.wb_byte !== 1'b1 ||
        bus.wb_en !== 1'b0 || bus.alu_enable[14] !== 1'b1) begin
      n_fail++;
      $display("FAIL cmp_byte_direct: got a=%h b=%h wbyte=%b we=%b en=%h expected a=00cd b=00cd wbyte=1 we=0 bit14",
               bus.alu_a, bus.alu_b, bus.wb_byte, bus.wb_en, bus.alu_enable);
    end
    step(1'b0, 16'h0000, 1'b1, 1'b0, t);
  endtask

  task automatic test_illegal();
    logic t;
    logic [15:0] words [5];
    words[0] = 16'h6000; words[1] = 16'h3FFF; words[2] = 16'h4C00;
    words[3] = 16'h4BC0; words[4] = 16'h4913;
    step(1'b1, words[0], 1'b1, 1'b0, t);
    n_checks++;
    if (bus.illegal !== 1'b1 || bus.alu_enable !== 41'd0 || bus.wb_en !== 1'b0 ||
        bus.out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL illegal_direct: got ill=%b en=%h we=%b v=%b expected ill=1 en=0 we=0 v=1",
               bus.illegal, bus.alu_enable, bus.wb_en, bus.out_valid);
    end
    for (int i = 1; i < 5; i++) step(1'b1, words[i], 1'b1, 1'b0, t);
    step(1'b0, 16'h0000, 1'b1, 1'b0, t);
  endtask

  task automatic test_back_to_back();
    logic t;
    int ptr;
    logic [15:0] ops [6];
    ops[0] = 16'h4101; ops[1] = 16'h4612; ops[2] = 16'h47C3;
    ops[3] = 16'h4824; ops[4] = 16'h4B35; ops[5] = 16'h4A46;
    for (int i = 0; i < 8; i++) rf[i] = 16'($urandom);
    n_pushed = 0;
    n_popped = 0;
    ptr = 0;
    for (int cyc = 0; cyc < 30 && (ptr < 6 || q.size() > 0); cyc++) begin
      bus.psw_c = cyc[0];
      step(ptr < 6, ops[ptr % 6], !(cyc >= 2 && cyc < 5), 1'b0, t);
      if (t) ptr++;
    end
    n_checks++;
    if (ptr != 6 || n_pushed != 6 || n_popped != 6 || q.size() != 0) begin
      n_fail++;
      $display("FAIL stream_count: got issued=%0d pushed=%0d popped=%0d left=%0d expected 6/6/6/0",
               ptr, n_pushed, n_popped, q.size());
    end
  endtask

  task automatic test_flush();
    logic t;
    step(1'b1, 16'h4000, 1'b0, 1'b0, t);
    step(1'b1, 16'h4700, 1'b0, 1'b1, t);
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.illegal !== 1'b0 || bus.wb_en !== 1'b0 ||
        bus.alu_enable !== 41'd0) begin
      n_fail++;
      $display("FAIL flush_clear: got v=%b ill=%b we=%b en=%h expected all zero",
               bus.out_valid, bus.illegal, bus.wb_en, bus.alu_enable);
    end
    step(1'b0, 16'h0000, 1'b1, 1'b0, t);
    step(1'b1, 16'h6000, 1'b0, 1'b0, t);
    step(1'b0, 16'h0000, 1'b1, 1'b1, t);
    n_checks++;
    if (bus.illegal !== 1'b0 || bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_illegal: got ill=%b v=%b expected 0 0", bus.illegal, bus.out_valid);
    end
    step(1'b0, 16'h0000, 1'b1, 1'b0, t);
  endtask

  task automatic test_async_reset();
    logic t;
    step(1'b1, 16'h4A00, 1'b0, 1'b0, t);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.alu_enable !== 41'd0 || bus.wb_en !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: got v=%b en=%h we=%b expected 0 0 0",
               bus.out_valid, bus.alu_enable, bus.wb_en);
    end
    q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(1'b0, 16'h0000, 1'b1, 1'b0, t);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    n_pushed = 0;
    n_popped = 0;
    test_reset();
    @(posedge clk);
    #1;
    test_add();
    test_subc_const();
    test_cmp_byte();
    test_illegal();
    test_back_to_back();
    test_flush();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
